// File: rtl/tlp_req_arbiter_if.sv
// Bundle of requester, packet-generator and completion-checker signals for tlp_req_arbiter.
// master = arbiter side, slave = requesters / generator / checker side.
interface tlp_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [3*NUM_REQ-1:0]  req_type;
  logic [64*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [1:0]            rsp_status;

  logic [2:0]  tx_type;
  logic [7:0]  tx_tag;
  logic [63:0] tx_addr;
  logic [31:0] tx_data;
  logic        tx_start;
  logic        tx_done;

  logic        rx_type;
  logic [7:0]  rx_tag;
  logic [31:0] rx_data;
  logic        rx_good;
  logic        rx_bad;

  modport master (
    input  req_valid, req_type, req_addr, req_data, tx_done, rx_good, rx_bad,
    output req_ready, rsp_valid, rsp_status,
    output tx_type, tx_tag, tx_addr, tx_data, tx_start,
    output rx_type, rx_tag, rx_data
  );

  modport slave (
    output req_valid, req_type, req_addr, req_data, tx_done, rx_good, rx_bad,
    input  req_ready, rsp_valid, rsp_status,
    input  tx_type, tx_tag, tx_addr, tx_data, tx_start,
    input  rx_type, rx_tag, rx_data
  );
endinterface

// File: rtl/tlp_req_arbiter.sv
// Shares one PIO packet generator/checker pair between NUM_REQ requesters.
// Define TLP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module tlp_req_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter int         CPL_TIMEOUT = 1024,
  parameter logic [7:0] TAG_INIT    = 8'd0
) (
  input  logic              user_clk,
  input  logic              reset,
  input  logic              user_lnk_up,
  tlp_req_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(CPL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPL_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, TX_WAIT, CPL_WAIT, RESP} state_e;
  typedef enum logic [1:0] {ST_OK, ST_BAD_CPL, ST_TIMEOUT, ST_LINK_ABORT} status_e;

  state_e             state;
  status_e            rsp_status_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         tx_type_q;
  logic [7:0]         tx_tag_q;
  logic [63:0]        tx_addr_q;
  logic [31:0]        tx_data_q;
  logic               tx_start_q;
  logic               rx_type_q;
  logic [31:0]        rx_data_q;

  logic [2:0]  type_a [NUM_REQ];
  logic [63:0] addr_a [NUM_REQ];
  logic [31:0] data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign type_a[i] = bus.req_type[3*i +: 3];
    assign addr_a[i] = bus.req_addr[64*i +: 64];
    assign data_a[i] = bus.req_data[32*i +: 32];
  end

  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;

`ifdef TLP_ARB_FIXED_PRIO_EN
  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        grant_idx = IDX_W'(i);
        grant_any = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  // Scan offsets downwards so the candidate nearest the pointer wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (bus.req_valid[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
  end
`endif

  logic    is_posted;
  logic    fin;
  status_e fin_status;

  assign is_posted = !(tx_type_q inside {3'b000, 3'b010, 3'b100, 3'b101});

  // NOTE: defaults come first so every path assigns fin/fin_status and no latch is inferred.
  always_comb begin
    fin        = 1'b0;
    fin_status = ST_OK;
    case (state)
      ISSUE: begin
        if (!user_lnk_up) begin
          fin        = 1'b1;
          fin_status = ST_LINK_ABORT;
        end
      end
      TX_WAIT: begin
        if (!user_lnk_up) begin
          fin        = 1'b1;
          fin_status = ST_LINK_ABORT;
        end else if (bus.tx_done && is_posted) begin
          fin = 1'b1;
        end
      end
      CPL_WAIT: begin
        if (!user_lnk_up) begin
          fin        = 1'b1;
          fin_status = ST_LINK_ABORT;
        end else if (bus.rx_bad) begin
          fin        = 1'b1;
          fin_status = ST_BAD_CPL;
        end else if (bus.rx_good) begin
          fin = 1'b1;
        end else if (cnt == CNT_MAX) begin
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state        <= IDLE;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_status_q <= ST_OK;
      owner        <= '0;
      cnt          <= '0;
      tx_type_q    <= '0;
      tx_tag_q     <= TAG_INIT - 8'd1;
      tx_addr_q    <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      rx_type_q    <= 1'b0;
      rx_data_q    <= '0;
`ifndef TLP_ARB_FIXED_PRIO_EN
      rr_ptr       <= '0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      tx_start_q  <= 1'b0;
      if (fin) begin
        state        <= RESP;
        rsp_valid_q  <= NUM_REQ'(1) << owner;
        rsp_status_q <= fin_status;
      end else begin
        case (state)
          IDLE: begin
            if (user_lnk_up && grant_any) begin
              owner                  <= grant_idx;
              tx_type_q              <= type_a[grant_idx];
              tx_addr_q              <= addr_a[grant_idx];
              tx_data_q              <= data_a[grant_idx];
              rx_data_q              <= data_a[grant_idx];
              rx_type_q              <= type_a[grant_idx] inside {3'b000, 3'b010, 3'b100};
              tx_tag_q               <= tx_tag_q + 8'd1;
              req_ready_q[grant_idx] <= 1'b1;
              state                  <= ISSUE;
            end
          end
          ISSUE: begin
            tx_start_q <= 1'b1;
            state      <= TX_WAIT;
          end
          TX_WAIT: begin
            if (bus.tx_done) begin
              cnt   <= '0;
              state <= CPL_WAIT;
            end
          end
          CPL_WAIT: cnt <= cnt + 1'b1;
          RESP: begin
            rsp_status_q <= ST_OK;
`ifndef TLP_ARB_FIXED_PRIO_EN
            rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.tx_type    = tx_type_q;
  assign bus.tx_tag     = tx_tag_q;
  assign bus.tx_addr    = tx_addr_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.rx_type    = rx_type_q;
  assign bus.rx_tag     = tx_tag_q;
  assign bus.rx_data    = rx_data_q;

endmodule

// File: tb/tb_tlp_req_arbiter.sv
// Self-checking bench for tlp_req_arbiter: vector table, scoreboard queues and corner sequences.
`timescale 1ns/1ps
module tb_tlp_req_arbiter;
  localparam int         NUM_REQ     = 4;
  localparam int         CPL_TIMEOUT = 16;
  localparam logic [7:0] TAG_INIT    = 8'd0;
  localparam logic [7:0] TAG_RST     = TAG_INIT - 8'd1;

  typedef enum int {K_POSTED, K_GOOD, K_BAD, K_BOTH, K_TIMEOUT, K_LINK} cpl_e;
  typedef struct {
    int          idx;
    logic [2:0]  ty;
    logic [63:0] addr;
    logic [31:0] data;
    cpl_e        cpl;
    int          dly;
    logic [1:0]  st;
  } vec_t;
  typedef struct {
    int          idx;
    logic [7:0]  tag;
    logic [2:0]  ty;
    logic [63:0] addr;
    logic [31:0] data;
  } grant_t;
  typedef struct {
    int         idx;
    logic [1:0] st;
  } rsp_t;

  logic user_clk;
  logic reset;
  logic user_lnk_up;

  tlp_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  tlp_req_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .CPL_TIMEOUT(CPL_TIMEOUT),
    .TAG_INIT   (TAG_INIT)
  ) dut (
    .user_clk   (user_clk),
    .reset      (reset),
    .user_lnk_up(user_lnk_up),
    .bus        (bus)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int       n_checks = 0;
  int       n_errors = 0;
  grant_t   grant_q[$];
  rsp_t     rsp_q[$];
  logic [7:0] exp_tag;
  int       rr_ptr_m;
  vec_t     vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge user_clk);
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    return NUM_REQ'(1) << i;
  endfunction

  function automatic logic exp_rx_type(input logic [2:0] t);
    return (t == 3'b000) || (t == 3'b010) || (t == 3'b100);
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
`ifdef TLP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
    for (int k = 0; k < NUM_REQ; k++) if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  task automatic set_req(input int idx, input logic [2:0] ty, input logic [63:0] addr,
                         input logic [31:0] data);
    bus.req_type[idx*3 +: 3]   = ty;
    bus.req_addr[idx*64 +: 64] = addr;
    bus.req_data[idx*32 +: 32] = data;
  endtask

  task automatic expect_txn(input int idx, input logic [2:0] ty, input logic [63:0] addr,
                            input logic [31:0] data, input logic [1:0] st);
    grant_q.push_back('{idx, exp_tag, ty, addr, data});
    rsp_q.push_back('{idx, st});
    exp_tag  = exp_tag + 8'd1;
    rr_ptr_m = (idx + 1) % NUM_REQ;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_req_ready"},  bus.req_ready, 0);
    check({pfx, "_rsp_valid"},  bus.rsp_valid, 0);
    check({pfx, "_rsp_status"}, bus.rsp_status, 0);
    check({pfx, "_tx_start"},   bus.tx_start, 0);
    check({pfx, "_tx_type"},    bus.tx_type, 0);
    check({pfx, "_tx_tag"},     bus.tx_tag, TAG_RST);
    check({pfx, "_rx_tag"},     bus.rx_tag, TAG_RST);
    check({pfx, "_tx_addr"},    bus.tx_addr, 0);
    check({pfx, "_tx_data"},    bus.tx_data, 0);
    check({pfx, "_rx_type"},    bus.rx_type, 0);
    check({pfx, "_rx_data"},    bus.rx_data, 0);
  endtask

  // Scoreboard: compare grants and responses against what the stimulus queued.
  grant_t g_m;
  rsp_t   r_m;
  always @(negedge user_clk) begin
    if (bus.req_ready != '0) begin
      if (grant_q.size() == 0) check("unexpected_grant", bus.req_ready, 0);
      else begin
        g_m = grant_q.pop_front();
        check("grant_onehot", bus.req_ready, onehot(g_m.idx));
        check("tx_tag",  bus.tx_tag,  g_m.tag);
        check("rx_tag",  bus.rx_tag,  g_m.tag);
        check("tx_type", bus.tx_type, g_m.ty);
        check("tx_addr", bus.tx_addr, g_m.addr);
        check("tx_data", bus.tx_data, g_m.data);
        check("rx_data", bus.rx_data, g_m.data);
        check("rx_type", bus.rx_type, exp_rx_type(g_m.ty));
      end
    end
    if (bus.rsp_valid != '0) begin
      if (rsp_q.size() == 0) check("unexpected_rsp", bus.rsp_valid, 0);
      else begin
        r_m = rsp_q.pop_front();
        check("rsp_onehot", bus.rsp_valid, onehot(r_m.idx));
        check("rsp_status", bus.rsp_status, r_m.st);
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int waited;
    set_req(v.idx, v.ty, v.addr, v.data);
    expect_txn(v.idx, v.ty, v.addr, v.data, v.st);
    bus.req_valid[v.idx] = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!bus.req_ready[v.idx] && waited < 20);
    bus.req_valid[v.idx] = 1'b0;
    check("grant_seen", bus.req_ready[v.idx], 1);
    if (!bus.req_ready[v.idx]) return;
    tick();
    check("tx_start", bus.tx_start, 1);
    tick();
    check("tx_start_pulse", bus.tx_start, 0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    if (v.cpl == K_POSTED) begin
      check("rsp_posted", bus.rsp_valid, onehot(v.idx));
    end else if (v.cpl == K_TIMEOUT) begin
      waited = 0;
      while (!bus.rsp_valid[v.idx] && waited < CPL_TIMEOUT + 8) begin
        tick();
        waited++;
      end
      check("timeout_cycles", waited, CPL_TIMEOUT);
    end else begin
      repeat (v.dly - 1) tick();
      case (v.cpl)
        K_GOOD:  bus.rx_good = 1'b1;
        K_BAD:   bus.rx_bad  = 1'b1;
        K_BOTH:  begin bus.rx_good = 1'b1; bus.rx_bad = 1'b1; end
        default: user_lnk_up = 1'b0;
      endcase
      tick();
      bus.rx_good = 1'b0;
      bus.rx_bad  = 1'b0;
      user_lnk_up = 1'b1;
      check("rsp_after_event", bus.rsp_valid, onehot(v.idx));
    end
    tick();
    check("rsp_pulse", bus.rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by t=%0t, checks %0d", $time, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  ty_a   [NUM_REQ];
    logic [63:0] addr_a [NUM_REQ];
    logic [31:0] data_a [NUM_REQ];
    int          waited;
    int          gi;

    reset         = 1'b1;
    user_lnk_up   = 1'b0;
    bus.req_valid = '0;
    bus.req_type  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    bus.rx_good   = 1'b0;
    bus.rx_bad    = 1'b0;
    exp_tag       = TAG_INIT;
    rr_ptr_m      = 0;

    vecs[0] = '{0, 3'b001, 64'h0000_0000_8000_0010, 32'h1234_5678, K_POSTED,  0,  2'b00};
    vecs[1] = '{1, 3'b000, 64'h0000_0000_0000_1000, 32'hCAFE_F00D, K_GOOD,    10, 2'b00};
    vecs[2] = '{1, 3'b000, 64'h0000_0000_0000_1004, 32'hCAFE_F00D, K_BOTH,    5,  2'b01};
    vecs[3] = '{2, 3'b010, 64'h0000_0001_2345_6780, 32'hDEAD_BEEF, K_TIMEOUT, 0,  2'b10};
    vecs[4] = '{3, 3'b100, 64'h0000_0000_0000_0040, 32'h0000_00A5, K_BAD,     1,  2'b01};
    vecs[5] = '{0, 3'b101, 64'h0000_0000_0000_0044, 32'h5A5A_0000, K_GOOD,    16, 2'b00};
    vecs[6] = '{3, 3'b011, 64'hFFFF_0000_0000_0100, 32'h0BAD_F00D, K_POSTED,  0,  2'b00};
    vecs[7] = '{2, 3'b110, 64'h0000_0000_0000_0200, 32'h7777_1111, K_POSTED,  0,  2'b00};
    vecs[8] = '{1, 3'b000, 64'h0000_0000_0000_0300, 32'h1357_9BDF, K_LINK,    3,  2'b11};

    repeat (3) tick();
    check_reset_vals("rst");
    reset       = 1'b0;
    user_lnk_up = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Link down: a pending request must not be granted until the link returns.
    user_lnk_up = 1'b0;
    set_req(3, 3'b001, 64'h0000_0000_0000_0500, 32'h2468_ACE0);
    bus.req_valid[3] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("no_grant_link_down", bus.req_ready, 0);
    end
    user_lnk_up = 1'b1;
    run_txn('{3, 3'b001, 64'h0000_0000_0000_0500, 32'h2468_ACE0, K_POSTED, 0, 2'b00});

    // Reset while waiting for tx_done: no response, outputs return to reset values.
    set_req(0, 3'b000, 64'h0000_0000_0000_ABCD, 32'h0000_0001);
    grant_q.push_back('{0, exp_tag, 3'b000, 64'h0000_0000_0000_ABCD, 32'h0000_0001});
    bus.req_valid[0] = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!bus.req_ready[0] && waited < 20);
    bus.req_valid[0] = 1'b0;
    check("rst_grant_seen", bus.req_ready[0], 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset    = 1'b0;
    exp_tag  = TAG_INIT;
    rr_ptr_m = 0;
    tick();
    bus.tx_done = 1'b1;
    bus.rx_good = 1'b1;
    bus.rx_bad  = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    bus.rx_good = 1'b0;
    bus.rx_bad  = 1'b0;
    tick();
    check("idle_ignores_rsp", bus.rsp_valid, 0);
    check("idle_ignores_start", bus.tx_start, 0);

    // All requesters held: eight posted writes in arbitration order.
    for (int i = 0; i < NUM_REQ; i++) begin
      ty_a[i]   = (i % 2 == 0) ? 3'b001 : 3'b011;
      addr_a[i] = 64'(i + 1) << 12;
      data_a[i] = 32'hA000_0000 + 32'(i);
      set_req(i, ty_a[i], addr_a[i], data_a[i]);
    end
    for (int n = 0; n < 8; n++) begin
      gi = pick('1, rr_ptr_m);
      expect_txn(gi, ty_a[gi], addr_a[gi], data_a[gi], 2'b00);
    end
    bus.req_valid = '1;
    for (int n = 0; n < 8; n++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (bus.req_ready == '0 && waited < 20);
      check("rr_grant_seen", |bus.req_ready, 1);
      if (n == 7) bus.req_valid = '0;
      tick();
      check("rr_tx_start", bus.tx_start, 1);
      tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      check("rr_rsp_seen", |bus.rsp_valid, 1);
    end
    bus.req_valid = '0;
    tick();

    // Enough posted writes to carry the tag through 0xFF -> 0x00.
    for (int n = 0; n < 256; n++) begin
      run_txn('{n % NUM_REQ, (n % 2 == 0) ? 3'b001 : 3'b011, 64'(n) << 4,
                32'(n) ^ 32'h5555_AAAA, K_POSTED, 0, 2'b00});
    end
    check("tag_after_wrap", bus.tx_tag, exp_tag - 8'd1);

    repeat (3) tick();
    check("grant_q_drained", grant_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
